cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Consumer end of the ALU decode interface: takes FlagW/NoWrite from the ALU decoder plus PCS/RegW/MemW from the main decoder.
- Holds the architectural NZCV flag registers and evaluates the instruction's 4-bit condition field against them.
- Gates architectural writes and the PC source with the condition result.
- Sits between the control decoders and the datapath write enables; also provides a registered condition result for multicycle sequencing.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into {N,Z,C,V} on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall (no state update).
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  2  flag write request from ALU decoder: [1] = N,Z; [0] = C,V.
- NoWrite  in  1  compare-class instruction; suppresses register write.
- PCS  in  1  decoder request to write PC.
- RegW  in  1  decoder request to write register file.
- MemW  in  1  decoder request to write memory.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- CondEx  out  1  combinational condition-passed result.
- CondExReg  out  1  CondEx registered on the last enabled cycle.
- Flags  out  4  current architectural {N,Z,C,V}.

Behaviour:
- Reset (sync, clk edge with reset=1): Flags <= RESET_FLAGS; CondExReg <= 0. Reset has priority over en and any flag write in the same cycle.
- Condition decode, combinational on registered Flags:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 reserved: CondEx = 0.
- Gated outputs, combinational, zero latency:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
- Flag update on clk edge when en=1 and reset=0:
  - FlagW[1] & CondEx: N,Z <= ALUFlags[3:2].
  - FlagW[0] & CondEx: C,V <= ALUFlags[1:0].
  - Halves update independently. Failed condition leaves Flags unchanged.
- Flag visibility: new flags are visible on Flags and to CondEx from the next cycle. Same-cycle write-then-read returns the old value unless FLAG_FORWARD_EN is defined.
- CondExReg <= CondEx on every enabled edge.
- Stall (en=0): Flags and CondExReg hold. Combinational gated outputs still track their inputs.
- Reset mid-instruction: any in-flight flag write is dropped; outputs settle from reset flags next cycle.

Optional Feature:
- Macro FLAG_FORWARD_EN.
- When defined, the condition evaluator uses forwarded flags: ALUFlags replaces the corresponding half of Flags when that half's FlagW bit is set and the registered CondExReg is 1. This supports back-to-back pipelined flag-set then conditional use.
- Flags output always shows registered state.
- When undefined, evaluation uses registered Flags only; 1-cycle flag latency as above.

Test Plan:
- Reset with RESET_FLAGS=0 -> Flags=0000, CondExReg=0. Cond=0000 (EQ) -> CondEx=0; Cond=1110 -> CondEx=1.
- Flags=0000, Cond=1110, FlagW=11, ALUFlags=0100, en=1 -> next cycle Flags=0100. Cond=0000 -> CondEx=1; RegW=1 -> RegWrite=1.
- Flags=0100, Cond=0001 (NE), FlagW=11, ALUFlags=1000, RegW=1, MemW=1, PCS=1 -> PCSrc=RegWrite=MemWrite=0; Flags stay 0100.
- Cond=1110, FlagW=10, NoWrite=1, RegW=1, ALUFlags=1011 from Flags=0100 -> RegWrite=0; next Flags=1000 (C,V untouched).
- Flags=1001: Cond=1010 (GE) -> 1, 1011 (LT) -> 0, 1100 (GT) -> 1, 1111 -> 0. Sweep all 16 codes × 16 flag values against the reference model.
- en=0 with FlagW=11, Cond=1110, ALUFlags=1111 -> Flags and CondExReg unchanged. Assert reset together with a valid write -> Flags=RESET_FLAGS.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Condition-check and flag-register unit: holds NZCV, evaluates the condition field, gates write enables.
// Optional FLAG_FORWARD_EN: condition evaluation sees ALU flags being written by the previous passed instruction.
module cond_flag_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       NoWrite,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic       CondExReg,
   output logic [3:0] Flags
);

   logic [3:0] flags_p1;
   logic       condexreg_p1;
   logic [3:0] eval_flags;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      logic r;
      {n, z, cy, v} = f;
      case (c)
         4'b0000: r = z;
         4'b0001: r = ~z;
         4'b0010: r = cy;
         4'b0011: r = ~cy;
         4'b0100: r = n;
         4'b0101: r = ~n;
         4'b0110: r = v;
         4'b0111: r = ~v;
         4'b1000: r = cy & ~z;
         4'b1001: r = ~cy | z;
         4'b1010: r = (n == v);
         4'b1011: r = (n != v);
         4'b1100: r = ~z & (n == v);
         4'b1101: r = z | (n != v);
         4'b1110: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   always_comb begin
      eval_flags = flags_p1;
`ifdef FLAG_FORWARD_EN
      // CondExReg qualifies the previous instruction's flag write as having actually happened.
      if (FlagW[1] & condexreg_p1) eval_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] & condexreg_p1) eval_flags[1:0] = ALUFlags[1:0];
`endif
   end

   assign CondEx   = cond_pass(Cond, eval_flags);
   assign PCSrc    = PCS & CondEx;
   assign RegWrite = RegW & CondEx & ~NoWrite;
   assign MemWrite = MemW & CondEx;

   // Architectural flag / condition registers
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_p1     <= RESET_FLAGS;
         condexreg_p1 <= 1'b0;
      end else if (en) begin
         if (FlagW[1] & CondEx) flags_p1[3:2] <= ALUFlags[3:2];
         if (FlagW[0] & CondEx) flags_p1[1:0] <= ALUFlags[1:0];
         condexreg_p1 <= CondEx;
      end
   end

   assign Flags     = flags_p1;
   assign CondExReg = condexreg_p1;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_cond_flag_unit;

   localparam logic [3:0] RESET_FLAGS = 4'b0000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [3:0] Cond = 4'b0000;
   logic [3:0] ALUFlags = 4'b0000;
   logic [1:0] FlagW = 2'b00;
   logic       NoWrite = 1'b0, PCS = 1'b0, RegW = 1'b0, MemW = 1'b0;
   logic       PCSrc, RegWrite, MemWrite, CondEx, CondExReg;
   logic [3:0] Flags;

   cond_flag_unit #(.RESET_FLAGS(RESET_FLAGS)) dut (
      .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
      .FlagW(FlagW), .NoWrite(NoWrite), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .CondExReg(CondExReg), .Flags(Flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pcsrc, regwrite, memwrite, condex, cexr;
      logic [3:0] flags;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   issued = 0;

   // Reference state: architectural flags and the registered condition bit
   logic [3:0] m_flags = RESET_FLAGS;
   logic       m_cexr  = 1'b0;

   // ARM-style evaluation: even codes name a test, odd codes invert it; 111x is always / never.
   function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
      bit n = f[3], z = f[2], cy = f[1], v = f[0];
      bit base;
      if (c[3:1] == 3'd7) return (c[0] == 1'b0);
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic drive(input logic rst_i, input logic en_i, input logic [3:0] cond_i,
                        input logic [3:0] alu_i, input logic [1:0] fw_i, input logic nw_i,
                        input logic pcs_i, input logic regw_i, input logic memw_i);
      exp_t e;
      logic [3:0] eff;
      logic ce;
      reset = rst_i; en = en_i; Cond = cond_i; ALUFlags = alu_i; FlagW = fw_i;
      NoWrite = nw_i; PCS = pcs_i; RegW = regw_i; MemW = memw_i;
      eff = m_flags;
`ifdef FLAG_FORWARD_EN
      if (fw_i[1] && m_cexr) eff[3:2] = alu_i[3:2];
      if (fw_i[0] && m_cexr) eff[1:0] = alu_i[1:0];
`endif
      ce = m_cond(cond_i, eff);
      e.condex   = ce;
      e.pcsrc    = pcs_i && ce;
      e.regwrite = regw_i && ce && !nw_i;
      e.memwrite = memw_i && ce;
      e.cexr     = m_cexr;
      e.flags    = m_flags;
      e.id       = issued;
      issued++;
      exp_q.push_back(e);
      if (rst_i) begin
         m_flags = RESET_FLAGS;
         m_cexr  = 1'b0;
      end else if (en_i) begin
         if (fw_i[1] && ce) m_flags[3:2] = alu_i[3:2];
         if (fw_i[0] && ce) m_flags[1:0] = alu_i[1:0];
         m_cexr = ce;
      end
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s vec %0d: got %b expected %b", nm, id, act, req);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("CondEx",    e.id, {3'b0, CondEx},    {3'b0, e.condex});
         chk("PCSrc",     e.id, {3'b0, PCSrc},     {3'b0, e.pcsrc});
         chk("RegWrite",  e.id, {3'b0, RegWrite},  {3'b0, e.regwrite});
         chk("MemWrite",  e.id, {3'b0, MemWrite},  {3'b0, e.memwrite});
         chk("CondExReg", e.id, {3'b0, CondExReg}, {3'b0, e.cexr});
         chk("Flags",     e.id, Flags,             e.flags);
      end
   end

   initial begin
      int waitc;
      @(posedge clk); #1;
      // Reset state, EQ and AL
      drive(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
      drive(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0);
      drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
      // Set Z, then EQ passes
      drive(0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
      drive(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0);
      // NE fails: everything gated, flags kept
      drive(0, 1, 4'b0001, 4'b1000, 2'b11, 0, 1, 1, 1);
      // NoWrite compare, only N,Z half written
      drive(0, 1, 4'b1110, 4'b1011, 2'b10, 1, 0, 1, 0);
      drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
      // Only C,V half written
      drive(0, 1, 4'b1110, 4'b0001, 2'b01, 0, 0, 0, 0);
      drive(0, 0, 4'b1010, 4'b0000, 2'b00, 0, 0, 1, 0);
      drive(0, 0, 4'b1011, 4'b0000, 2'b00, 0, 0, 1, 0);
      drive(0, 0, 4'b1100, 4'b0000, 2'b00, 0, 0, 1, 0);
      drive(0, 0, 4'b1111, 4'b0000, 2'b00, 0, 1, 1, 1);
      // Stall with a would-be write
      drive(0, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
      drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
      // Reset together with a valid write
      drive(1, 1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
      drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
      // Sweep all codes against all flag values
      for (int f = 0; f < 16; f++) begin
         drive(0, 1, 4'b1110, 4'(f), 2'b11, 0, 0, 0, 0);
         for (int c = 0; c < 16; c++)
            drive(0, 0, 4'(c), 4'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
      end
      // Random traffic with occasional stalls and resets
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), 4'($urandom),
               4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      waitc = 0;
      while (exp_q.size() > 0 && waitc < 10) begin
         @(posedge clk);
         waitc++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
